// File: rtl/gate_pkg.sv
// Shared types for the vector gate unit: operation codes and their width.
package gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

endpackage

// File: rtl/gate_bitwise.sv
// Combinational bitwise gate function over WIDTH-bit operands.
module gate_bitwise
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_BUF:  y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/gate_logic_unit.sv
// Registered vector gate unit with valid/ready handshake and a result
// accumulator that can stand in for operand A on later beats.
module gate_logic_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] result;
    logic             accept;

    // Handshake: a beat transfers on a cycle where valid && ready are both 1.
    // Upstream may accept whenever the output slot is empty or being drained
    // this cycle, so in_ready depends combinationally on out_ready only.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !rst;
    assign opnd_a   = in_acc ? acc : in_a;

    gate_bitwise #(
        .WIDTH(WIDTH)
    ) u_bitwise (
        .op(op_e'(in_op)),
        .a (opnd_a),
        .b (in_b),
        .y (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_ones  <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_zero  <= ~|result;
            out_ones  <= &result;
            acc       <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
